// File: rtl/psum_reduce_reader_if.sv
// Purpose : bundles the psum_reduce_reader control, psum SRAM read and output SRAM write signals.
// Latency : none; this is only a bundle of wires.
// Backpressure: none; the sequencer starts a pass and the SRAMs accept one access per cycle.
// Ports   : start/n_out/n_kij (sequencer -> block), busy/done (block -> sequencer),
//           psum_cen/psum_addr/psum_q (psum SRAM read port), out_wen/out_addr/out_d (output SRAM write port).
interface psum_reduce_reader_if #(
  parameter int BW  = 16,
  parameter int COL = 8,
  parameter int AW  = 11,
  parameter int CW  = 8
) ();
  logic              start;
  logic [CW-1:0]     n_out;
  logic [CW-1:0]     n_kij;
  logic              busy;
  logic              done;
  logic              psum_cen;
  logic [AW-1:0]     psum_addr;
  logic [BW*COL-1:0] psum_q;
  logic              out_wen;
  logic [AW-1:0]     out_addr;
  logic [BW*COL-1:0] out_d;

  // The reduce block itself.
  modport slave (
    input  start, n_out, n_kij, psum_q,
    output busy, done, psum_cen, psum_addr, out_wen, out_addr, out_d
  );

  // Sequencer plus SRAM side.
  modport master (
    output start, n_out, n_kij, psum_q,
    input  busy, done, psum_cen, psum_addr, out_wen, out_addr, out_d
  );
endinterface

// File: rtl/psum_reduce_reader.sv
// Purpose : sweeps all kernel positions of each output pixel in psum SRAM, accumulates per lane, applies ReLU, writes output SRAM.
// Latency : n_kij+2 cycles per pixel, n_out*(n_kij+2) cycles per pass, then one done cycle.
// Backpressure: none; start is only accepted in IDLE and is ignored while a pass runs.
// Ports   : clk_i, reset_ni (async, active-low); port_if (slave modport) carries the control, psum read and output write signals.
module psum_reduce_reader #(
  parameter int BW  = 16,
  parameter int COL = 8,
  parameter int AW  = 11,
  parameter int CW  = 8
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  psum_reduce_reader_if.slave port_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_e;

  state_e                    state_q;
  logic [CW-1:0]             nout_q;
  logic [CW-1:0]             nkij_q;
  logic [CW-1:0]             o_q;
  logic [CW-1:0]             k_q;
  logic [AW-1:0]             ra_q;        // current read address, k*n_out + o built by repeated add
  logic                      rd_vld_q;    // psum_q carries data read in the previous cycle
  logic                      rd_first_q;  // that data is k=0 of a pixel
  logic [COL-1:0][BW-1:0]    acc_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      cen_q;
  logic                      out_wen_q;
  logic [AW-1:0]             out_addr_q;
  logic [COL-1:0][BW-1:0]    out_d_q;

  logic [COL-1:0][BW-1:0]    lane_q;
  logic [COL-1:0][BW-1:0]    acc_d;
  logic [COL-1:0][BW-1:0]    relu_d;

  assign lane_q = port_if.psum_q;

  // The DRAIN cycle both accumulates the last read and registers the write data,
  // so the ReLU is taken from the next-state accumulator rather than acc_q.
  always_comb begin
    acc_d  = acc_q;
    relu_d = '0;
    for (int i = 0; i < COL; i++) begin
      if (rd_vld_q) begin
        acc_d[i] = rd_first_q ? lane_q[i] : acc_q[i] + lane_q[i];
      end
      relu_d[i] = acc_d[i][BW-1] ? '0 : acc_d[i];
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      nout_q     <= '0;
      nkij_q     <= '0;
      o_q        <= '0;
      k_q        <= '0;
      ra_q       <= '0;
      rd_vld_q   <= 1'b0;
      rd_first_q <= 1'b0;
      acc_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cen_q      <= 1'b1;
      out_wen_q  <= 1'b1;
      out_addr_q <= '0;
      out_d_q    <= '0;
    end else begin
      rd_vld_q   <= (state_q == S_READ);
      rd_first_q <= (state_q == S_READ) && (k_q == '0);
      acc_q      <= acc_d;

      case (state_q)
        S_IDLE: begin
          if (port_if.start) begin
            nout_q <= port_if.n_out;
            nkij_q <= port_if.n_kij;
            o_q    <= '0;
            k_q    <= '0;
            ra_q   <= '0;
            if ((port_if.n_out == '0) || (port_if.n_kij == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_READ;
              busy_q  <= 1'b1;
              cen_q   <= 1'b0;
            end
          end
        end

        S_READ: begin
          if (k_q == nkij_q - CW'(1)) begin
            state_q <= S_DRAIN;
            cen_q   <= 1'b1;
          end else begin
            k_q  <= k_q + CW'(1);
            ra_q <= ra_q + AW'(nout_q);
          end
        end

        S_DRAIN: begin
          state_q    <= S_WRITE;
          out_wen_q  <= 1'b0;
          out_addr_q <= AW'(o_q);
          out_d_q    <= relu_d;
        end

        S_WRITE: begin
          out_wen_q <= 1'b1;
          if (o_q == nout_q - CW'(1)) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_READ;
            o_q     <= o_q + CW'(1);
            k_q     <= '0;
            ra_q    <= AW'(o_q) + AW'(1);  // next pixel starts at k=0, address o+1
            cen_q   <= 1'b0;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign port_if.busy      = busy_q;
  assign port_if.done      = done_q;
  assign port_if.psum_cen  = cen_q;
  assign port_if.psum_addr = ra_q;
  assign port_if.out_wen   = out_wen_q;
  assign port_if.out_addr  = out_addr_q;
  assign port_if.out_d     = out_d_q;

endmodule

// File: tb/tb_psum_reduce_reader.sv
// Purpose : randomized scoreboard bench for psum_reduce_reader with a memory-level reference model.
// Latency : expected done cycle derived from n_out*(n_kij+2)+1 (or 1 for an empty pass).
// Backpressure: none; the SRAM models answer every access.
module tb_psum_reduce_reader;
  localparam int BW  = 16;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam int CW  = 8;
  localparam int DW  = BW * COL;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  psum_reduce_reader_if #(.BW(BW), .COL(COL), .AW(AW), .CW(CW)) bus ();

  psum_reduce_reader #(.BW(BW), .COL(COL), .AW(AW), .CW(CW)) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .port_if  (bus)
  );

  logic [DW-1:0] mem [0:DEPTH-1];

  // psum SRAM: data appears one cycle after an enabled read.
  always @(posedge clk) begin
    if (!bus.psum_cen) bus.psum_q <= mem[bus.psum_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  int              exp_rd   [$];
  logic [AW+DW-1:0] exp_wr  [$];
  int              exp_done [$];
  int              busy_lo = 0;
  int              busy_hi = -1;
  logic [DW-1:0]   last_wd  = '0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: compares every visible DUT event against the scoreboard queues.
  always @(negedge clk) begin
    chk("busy", {159'd0, bus.busy}, {159'd0, (cyc >= busy_lo) && (cyc <= busy_hi)});
    chk("cen_wen_exclusive", {159'd0, !(!bus.psum_cen && !bus.out_wen)}, 160'd1);
    if (!bus.psum_cen) begin
      if (exp_rd.size() == 0) fail("unexpected_read");
      else chk("read_addr", {149'd0, bus.psum_addr}, exp_rd.pop_front());
    end
    if (!reset_n) begin
      last_wd = '0;
    end else if (!bus.out_wen) begin
      if (exp_wr.size() == 0) fail("unexpected_write");
      else chk("write_addr_data", {21'd0, bus.out_addr, bus.out_d}, {21'd0, exp_wr.pop_front()});
      last_wd = bus.out_d;
    end else begin
      chk("out_d_hold", {32'd0, bus.out_d}, {32'd0, last_wd});
    end
    if (bus.done) begin
      if (exp_done.size() == 0) fail("unexpected_done");
      else chk("done_cycle", cyc, exp_done.pop_front());
    end
  end

  // Reference: each output pixel o is the lane-wise wrapped sum of words
  // at (k*n_out + o) mod DEPTH, negatives clamped to zero.
  task automatic run_pass(input int nout, input int nkij);
    int n;
    logic signed [BW-1:0] s [COL];
    logic [DW-1:0] w;
    int a;
    n = (nout == 0 || nkij == 0) ? 1 : nout * (nkij + 2) + 1;
    if (nout != 0 && nkij != 0) begin
      for (int o = 0; o < nout; o++) begin
        for (int l = 0; l < COL; l++) s[l] = '0;
        for (int k = 0; k < nkij; k++) begin
          a = (k * nout + o) % DEPTH;
          exp_rd.push_back(a);
          for (int l = 0; l < COL; l++) s[l] = s[l] + mem[a][l*BW +: BW];
        end
        for (int l = 0; l < COL; l++) w[l*BW +: BW] = (s[l] < 0) ? '0 : s[l];
        exp_wr.push_back({AW'(o), w});
      end
      busy_lo = cyc + 1;
      busy_hi = cyc + n - 1;
    end
    exp_done.push_back(cyc + n);
    bus.start = 1'b1;
    bus.n_out = CW'(nout);
    bus.n_kij = CW'(nkij);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_rd.size() == 0 && exp_wr.size() == 0 && exp_done.size() == 0) break;
    end
    chk("pass_complete_pending", exp_rd.size() + exp_wr.size() + exp_done.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},      {159'd0, bus.busy}, 0);
    chk({tag, "_done"},      {159'd0, bus.done}, 0);
    chk({tag, "_psum_cen"},  {159'd0, bus.psum_cen}, 1);
    chk({tag, "_psum_addr"}, {149'd0, bus.psum_addr}, 0);
    chk({tag, "_out_wen"},   {159'd0, bus.out_wen}, 1);
    chk({tag, "_out_addr"},  {149'd0, bus.out_addr}, 0);
    chk({tag, "_out_d"},     {32'd0, bus.out_d}, 0);
  endtask

  task automatic fill_random;
    for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.n_out = '0;
    bus.n_kij = '0;
    for (int a = 0; a < DEPTH; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Basic pass: lane 0 only.
    mem[0][15:0] = 16'd5;   mem[2][15:0] = 16'hFFFD; mem[4][15:0] = 16'd10;
    mem[1][15:0] = 16'hFFF9; mem[3][15:0] = 16'd2;   mem[5][15:0] = 16'd1;
    run_pass(2, 3);
    wait_done(40);

    // Lane independence with random signed lanes.
    fill_random();
    run_pass(1, 4);
    wait_done(40);

    // Overflow wrap.
    for (int a = 0; a < 4; a++) mem[a] = '0;
    mem[0][15:0] = 16'h7FFF; mem[0][31:16] = 16'h7FFE;
    mem[1][15:0] = 16'h0001; mem[1][31:16] = 16'h0001;
    run_pass(1, 2);
    wait_done(40);

    // Zero counts.
    run_pass(5, 0);
    wait_done(20);
    run_pass(0, 3);
    wait_done(20);

    // Reset during READ of pixel 1, then a clean rerun.
    fill_random();
    run_pass(3, 3);
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    exp_done.delete();
    busy_hi = -1;
    #1 chk_reset_vals("mid_reset");
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    run_pass(3, 3);
    wait_done(60);

    // start while busy with different counts is ignored.
    run_pass(2, 3);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.n_out = 8'd4;
    bus.n_kij = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(40);

    // Random passes.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_pass($urandom_range(1, 6), $urandom_range(1, 6));
      wait_done(80);
    end

    // Address wrap modulo 2^AW.
    fill_random();
    run_pass(200, 12);
    wait_done(2900);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
